// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: Avalon request/response types and arbiter state enum shared by the arbiter slice
package mem_bus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byte_enable;
  } avalon_req_t;
  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
  } avalon_resp_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner (active[N], rr_ptr[W] -> any_active, winner[W]) via rotate, first-one scan, un-rotate
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] active,
  input  logic [W-1:0] rr_ptr,
  output logic         any_active,
  output logic [W-1:0] winner
);
  localparam logic [W:0] NV = (W+1)'(N);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  always_comb begin
    rot = N'({active, active} >> rr_ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    winner = (sum >= NV) ? W'(sum - NV) : W'(sum);
    any_active = |active;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: zero-latency round-robin arbiter sharing one Avalon port (clk, rst, master_req/master_resp[N] <-> mem_req/mem_resp)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MASTER_ID_WIDTH = NUM_MASTERS == 1 ? 1 : $clog2(NUM_MASTERS)
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  master_req [NUM_MASTERS],
  output avalon_resp_t master_resp [NUM_MASTERS],
  output avalon_req_t  mem_req,
  input  avalon_resp_t mem_resp
);
  localparam logic [MASTER_ID_WIDTH-1:0] LAST = MASTER_ID_WIDTH'(NUM_MASTERS - 1);
  arb_state_t state, state_n;
  logic [MASTER_ID_WIDTH-1:0] rr_ptr, rr_n, owner, owner_n, winner, sel;
  logic [NUM_MASTERS-1:0] active;
  logic any_active, go;
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_act
    assign active[i] = master_req[i].read | master_req[i].write;
  end
  rr_pick #(.N(NUM_MASTERS), .W(MASTER_ID_WIDTH)) u_pick (
    .active(active),
    .rr_ptr(rr_ptr),
    .any_active(any_active),
    .winner(winner)
  );
  // With nobody active, sel falls back to master 0 so its address/data are forwarded.
  // A dropped owner or an idle bus already has read/write low, so only reset needs gating.
  always_comb begin
    sel = (state == BUSY) ? owner : (any_active ? winner : '0);
    go = (state == BUSY) ? active[sel] : any_active;
    mem_req = master_req[sel];
    mem_req.read = master_req[sel].read & ~rst;
    mem_req.write = master_req[sel].write & ~rst;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      master_resp[i].readdata = mem_resp.readdata;
      master_resp[i].waitrequest = active[i] & (rst | (MASTER_ID_WIDTH'(i) != sel) | mem_resp.waitrequest);
    end
    state_n = go ? (mem_resp.waitrequest ? BUSY : IDLE) : IDLE;
    owner_n = (go && mem_resp.waitrequest) ? sel : owner;
    rr_n = (go && !mem_resp.waitrequest) ? ((sel == LAST) ? '0 : sel + 1'b1) : rr_ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      owner <= owner_n;
    end
  end
endmodule
